tape_csw_player: RTL

- Upstream source for the motherboard's tape_in pin: replays a CSW‑v1‑style pulse stream as a square‑wave tape signal.
- Pulls one byte per handshake from a byte stream (ioctl/SDRAM loader); each byte is one pulse length in sample periods.
- Toggles the output level at the end of each pulse.
- Runs only while the PPI tape_motor output is high.

---
 rtl/tape_csw_player.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tape_csw_player.sv
// CSW-v1 style pulse replayer: pulls one pulse length per byte (zero byte escapes to a
// 32-bit little-endian length) and toggles tape_in at the end of every pulse.
module tape_csw_player #(
  parameter int unsigned SAMPLE_DIV = 91
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       motor,
  input  logic       rewind,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_in,
  output logic       active,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXT0, S_EXT1, S_EXT2, S_EXT3, S_RUN, S_DONE
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(SAMPLE_DIV - 1);

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic        tape_q, tape_d;
  logic        underrun_q, underrun_d;
  logic        last_q, last_d;
  logic        loading;
  logic        accept;

  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      sample_cnt_q <= '0;
      tape_q       <= 1'b0;
      underrun_q   <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      tape_q       <= tape_d;
      underrun_q   <= underrun_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    tape_d       = tape_q;
    underrun_d   = underrun_q;
    last_d       = last_q;

    loading  = (state_q == S_FETCH) || (state_q == S_EXT0) || (state_q == S_EXT1) ||
               (state_q == S_EXT2) || (state_q == S_EXT3);
    in_ready = motor && loading;
    active   = motor && (loading || (state_q == S_RUN));
    accept   = in_ready && in_valid;

    // With motor low nothing advances; the player resumes exactly where it stopped.
    if (motor) begin
      if (ce && loading && !in_valid) underrun_d = 1'b1;
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: if (accept) begin
          if (in_last) last_d = 1'b1;
          if (in_data != 8'd0) begin
            len_d        = {24'd0, in_data};
            sample_cnt_d = '0;
            state_d      = S_RUN;
          end else begin
            len_d   = '0;
            state_d = S_EXT0;
          end
        end
        S_EXT0: if (accept) begin
          len_d[7:0] = in_data;
          state_d    = in_last ? S_DONE : S_EXT1;
        end
        S_EXT1: if (accept) begin
          len_d[15:8] = in_data;
          state_d     = in_last ? S_DONE : S_EXT2;
        end
        S_EXT2: if (accept) begin
          len_d[23:16] = in_data;
          state_d      = in_last ? S_DONE : S_EXT3;
        end
        S_EXT3: if (accept) begin
          len_d[31:24] = in_data;
          if ({in_data, len_q[23:0]} == 32'd0) len_d = 32'd1;
          if (in_last) last_d = 1'b1;
          sample_cnt_d = '0;
          state_d      = S_RUN;
        end
        S_RUN: if (ce) begin
          if (sample_cnt_q == CNT_MAX) begin
            sample_cnt_d = '0;
            if (len_q == 32'd1) begin
              tape_d  = ~tape_q;
              state_d = last_q ? S_DONE : S_FETCH;
            end else begin
              len_d = len_q - 32'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 16'd1;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tape_in  = tape_q;
  assign underrun = underrun_q;

endmodule
